// File: rtl/cpu_step_control_pkg.sv
// Shared definitions for the CPU clock-enable / single-step controller.
package cpu_step_control_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_STEP   = 2'd2,
        ST_HALTED = 2'd3
    } state_t;

    localparam int DEBOUNCE_CYCLES_DEF = 500000;

endpackage

// File: rtl/cpu_step_control_debounce.sv
// Level debouncer: output follows the input only after it has held a new
// value for DEBOUNCE_CYCLES consecutive clocks.
module button_debounce
    import cpu_step_control_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
    input  logic clk,
    input  logic clr,
    input  logic din,
    output logic dout
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [CW-1:0] cnt;

    // Any cycle where input agrees with the accepted level restarts the run.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            cnt  <= '0;
            dout <= 1'b0;
        end else if (din == dout) begin
            cnt  <= '0;
        end else if (cnt == LAST) begin
            cnt  <= '0;
            dout <= din;
        end else begin
            cnt  <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/cpu_step_control.sv
// Generates single-cycle CPU clock enables from a slow divided clock, in
// free-run or single-step mode, with halt handling and a pulse counter.
module cpu_step_control
    import cpu_step_control_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter int CNT_W           = 16
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             slow_clk,
    input  logic             run_sw,
    input  logic             step_btn,
    input  logic             halt_req,
    output logic             cpu_en,
    output logic             running,
    output logic             halted,
    output logic [CNT_W-1:0] step_count
);

    logic [1:0] slow_sync, run_sync, btn_sync;
    logic       slow_q, db_level, db_q;
    logic       tick, step_req, run_s, en_nxt;
    state_t     state, state_nxt;

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            slow_sync <= '0;
            run_sync  <= '0;
            btn_sync  <= '0;
            slow_q    <= 1'b0;
            db_q      <= 1'b0;
        end else begin
            slow_sync <= {slow_sync[0], slow_clk};
            run_sync  <= {run_sync[0], run_sw};
            btn_sync  <= {btn_sync[0], step_btn};
            slow_q    <= slow_sync[1];
            db_q      <= db_level;
        end
    end

    button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_debounce (
        .clk  (clk),
        .clr  (clr),
        .din  (btn_sync[1]),
        .dout (db_level)
    );

    assign tick     = slow_sync[1] & ~slow_q;
    assign step_req = db_level & ~db_q;
    assign run_s    = run_sync[1];

    always_comb begin
        state_nxt = state;
        en_nxt    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (run_s)         state_nxt = ST_RUN;
                else if (step_req) state_nxt = ST_STEP;
            end
            ST_RUN: begin
                if (!run_s)    state_nxt = ST_IDLE;
                else if (tick) en_nxt    = 1'b1;
            end
            ST_STEP: begin
                if (tick) begin
                    en_nxt    = 1'b1;
                    state_nxt = ST_IDLE;
                end
            end
            ST_HALTED: begin
                if (!halt_req && !run_s) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
        // Halt wins over every other transition and suppresses the pulse.
        if (halt_req && state != ST_HALTED) begin
            state_nxt = ST_HALTED;
            en_nxt    = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state      <= ST_IDLE;
            cpu_en     <= 1'b0;
            step_count <= '0;
        end else begin
            state  <= state_nxt;
            cpu_en <= en_nxt;
            if (en_nxt) step_count <= step_count + 1'b1;
        end
    end

    assign running = (state == ST_RUN);
    assign halted  = (state == ST_HALTED);

endmodule

// File: tb/tb_cpu_step_control.sv
// Directed bench: stimulus queues expected step_count per cpu_en pulse,
// an independent monitor pops and checks each pulse as it appears.
module tb_cpu_step_control;

    localparam int CNT_W = 4;

    logic             clk = 1'b0;
    logic             clr = 1'b0;
    logic             slow_clk = 1'b0;
    logic             run_sw = 1'b0;
    logic             step_btn = 1'b0;
    logic             halt_req = 1'b0;
    logic             cpu_en, running, halted;
    logic [CNT_W-1:0] step_count;

    int vectors = 0;
    int errors  = 0;
    int phase   = 19;
    int age     = 0;
    logic slow_q = 1'b0;
    logic en_q   = 1'b0;
    int exp_q[$];

    cpu_step_control #(.DEBOUNCE_CYCLES(4), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .clr        (clr),
        .slow_clk   (slow_clk),
        .run_sw     (run_sw),
        .step_btn   (step_btn),
        .halt_req   (halt_req),
        .cpu_en     (cpu_en),
        .running    (running),
        .halted     (halted),
        .step_count (step_count)
    );

    always #5 clk = ~clk;

    // slow_clk: 20-cycle period, high for phases 0..9, changes on negedge.
    initial begin
        forever begin
            @(negedge clk);
            phase = (phase + 1) % 20;
            slow_clk = (phase < 10);
        end
    end

    // Posedges elapsed since slow_clk was first sampled high (1 = that edge).
    always @(posedge clk) begin
        if (slow_clk && !slow_q) age <= 1;
        else                     age <= age + 1;
        slow_q <= slow_clk;
    end

    task automatic chk(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (en_q) chk("pulse_width", int'(cpu_en), 0);
        if (clr && cpu_en) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_pulse", int'(step_count), -1);
            end else begin
                chk("pulse_count", int'(step_count), exp_q.pop_front());
                chk("pulse_latency", age, 3);
            end
        end
        en_q <= cpu_en;
    end

    task automatic step_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic wait_phase(input int p);
        int n = 0;
        do begin
            @(negedge clk);
            #1;
            n++;
        end while (phase != p && n < 40);
        chk("phase_wait", phase, p);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        step_cycles(3);
        chk("rst_cpu_en", int'(cpu_en), 0);
        chk("rst_running", int'(running), 0);
        chk("rst_halted", int'(halted), 0);
        chk("rst_count", int'(step_count), 0);
        clr = 1'b1;

        // Free run for 3 slow periods
        wait_phase(10);
        exp_q.push_back(1); exp_q.push_back(2); exp_q.push_back(3);
        run_sw = 1'b1;
        step_cycles(59);
        chk("run_running", int'(running), 1);
        step_cycles(1);
        chk("run_phase_end", phase, 10);
        run_sw = 1'b0;
        step_cycles(5);
        chk("run_stopped", int'(running), 0);
        chk("run_count", int'(step_count), 3);
        chk("run_pending", exp_q.size(), 0);

        // Bouncing step button, then held
        wait_phase(10);
        exp_q.push_back(4);
        for (int i = 0; i < 10; i++) begin
            step_btn = ((i / 2) % 2 == 0);
            step_cycles(1);
        end
        step_btn = 1'b1;
        step_cycles(40);
        chk("step_count", int'(step_count), 4);
        chk("step_idle_run", int'(running), 0);
        chk("step_idle_halt", int'(halted), 0);
        chk("step_pending", exp_q.size(), 0);
        step_btn = 1'b0;
        step_cycles(10);

        // Halt one cycle before tick while running
        wait_phase(10);
        run_sw = 1'b1;
        wait_phase(1);
        halt_req = 1'b1;
        step_cycles(4);
        chk("halt_entered", int'(halted), 1);
        chk("halt_not_run", int'(running), 0);
        halt_req = 1'b0;
        step_cycles(25);
        chk("halt_hold_sw", int'(halted), 1);
        run_sw = 1'b0;
        step_cycles(4);
        chk("halt_release", int'(halted), 0);
        chk("halt_idle_run", int'(running), 0);
        chk("halt_count", int'(step_count), 4);

        // 17 free-run pulses: count wraps 15 -> 0 -> 1 ... -> 5
        wait_phase(10);
        for (int k = 1; k <= 17; k++) exp_q.push_back((4 + k) % 16);
        run_sw = 1'b1;
        step_cycles(340);
        run_sw = 1'b0;
        step_cycles(5);
        chk("wrap_count", int'(step_count), 5);
        chk("wrap_pending", exp_q.size(), 0);

        // Reset while a step is pending before its tick
        wait_phase(10);
        step_btn = 1'b1;
        wait_phase(19);
        chk("prerst_count", int'(step_count), 5);
        clr = 1'b0;
        step_btn = 1'b0;
        #1;
        chk("arst_cpu_en", int'(cpu_en), 0);
        chk("arst_count", int'(step_count), 0);
        chk("arst_running", int'(running), 0);
        chk("arst_halted", int'(halted), 0);
        wait_phase(2);
        clr = 1'b1;
        step_cycles(40);
        chk("postrst_count", int'(step_count), 0);

        // run_sw drops in the same cycle as the tick
        wait_phase(10);
        run_sw = 1'b1;
        wait_phase(0);
        run_sw = 1'b0;
        step_cycles(2);
        chk("coin_run_in_tick", int'(running), 1);
        step_cycles(1);
        chk("coin_run_after", int'(running), 0);
        step_cycles(20);
        chk("coin_count", int'(step_count), 0);
        chk("final_pending", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
